// File: rtl/mem_arbiter.sv
// Two-port fetch/data arbiter in front of a single-port memory.
// Serialises accesses as IDLE -> ISSUE -> RESP, one transaction per three cycles.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req_valid,
  output logic                  i_req_ready,
  input  logic [ADDR_WIDTH-1:0] i_req_addr,
  output logic                  i_rsp_valid,
  output logic [31:0]           i_rsp_data,
  output logic [1:0]            i_rsp_err,
  input  logic                  d_req_valid,
  output logic                  d_req_ready,
  input  logic                  d_req_we,
  input  logic [ADDR_WIDTH-1:0] d_req_addr,
  input  logic [31:0]           d_req_wdata,
  input  logic [1:0]            d_req_bmul,
  output logic                  d_rsp_valid,
  output logic [31:0]           d_rsp_data,
  output logic [1:0]            d_rsp_err,
  output logic                  mem_r_en,
  output logic [ADDR_WIDTH-1:0] mem_r_addr,
  output logic [1:0]            mem_r_bmul,
  output logic                  mem_w_en,
  output logic [ADDR_WIDTH-1:0] mem_w_addr,
  output logic [31:0]           mem_w_data,
  output logic [1:0]            mem_w_bmul,
  input  logic [31:0]           mem_r_data,
  input  logic [1:0]            mem_state,
  output logic                  err_sticky,
  output logic [ADDR_WIDTH-1:0] err_addr,
  output logic [1:0]            err_code
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RESP
  } state_t;

  state_t state, state_nx;

  // grant encoding: 0 = fetch port, 1 = data port
  logic                  last_grant;
  logic                  gnt_d;
  logic                  acc;
  logic                  acc_we;
  logic                  port_q;
  logic                  we_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            bmul_q;
  logic                  rsp_i_q;
  logic                  rsp_d_q;

  always_comb begin
    state_nx    = state;
    gnt_d       = 1'b0;
    i_req_ready = 1'b0;
    d_req_ready = 1'b0;
    acc         = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req_valid && d_req_valid)
          gnt_d = ~last_grant;
        else
          gnt_d = d_req_valid;
        i_req_ready = i_req_valid && !gnt_d;
        d_req_ready = d_req_valid && gnt_d;
        acc         = i_req_ready || d_req_ready;
        if (acc)
          state_nx = ISSUE;
      end
      ISSUE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign acc_we = gnt_d && d_req_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      bmul_q     <= '0;
      mem_r_en   <= 1'b0;
      mem_w_en   <= 1'b0;
      rsp_i_q    <= 1'b0;
      rsp_d_q    <= 1'b0;
      err_sticky <= 1'b0;
      err_addr   <= '0;
      err_code   <= '0;
    end else begin
      state    <= state_nx;
      mem_r_en <= 1'b0;
      mem_w_en <= 1'b0;
      rsp_i_q  <= 1'b0;
      rsp_d_q  <= 1'b0;
      if (acc) begin
        port_q     <= gnt_d;
        last_grant <= gnt_d;
        we_q       <= acc_we;
        addr_q     <= gnt_d ? d_req_addr : i_req_addr;
        wdata_q    <= gnt_d ? d_req_wdata : '0;
        bmul_q     <= gnt_d ? d_req_bmul : 2'b10;
        mem_r_en   <= !acc_we;
        mem_w_en   <= acc_we;
      end
      if (state == ISSUE) begin
        rsp_i_q <= !port_q;
        rsp_d_q <= port_q;
      end
      // only the first failing response is recorded
      if (state == RESP && mem_state != 2'b00 && !err_sticky) begin
        err_sticky <= 1'b1;
        err_addr   <= addr_q;
        err_code   <= mem_state;
      end
    end
  end

  assign mem_r_addr = addr_q;
  assign mem_r_bmul = bmul_q;
  assign mem_w_addr = addr_q;
  assign mem_w_data = wdata_q;
  assign mem_w_bmul = bmul_q;

  assign i_rsp_valid = rsp_i_q;
  assign i_rsp_data  = rsp_i_q ? mem_r_data : '0;
  assign i_rsp_err   = rsp_i_q ? mem_state : '0;
  assign d_rsp_valid = rsp_d_q;
  assign d_rsp_data  = (rsp_d_q && !we_q) ? mem_r_data : '0;
  assign d_rsp_err   = rsp_d_q ? mem_state : '0;

endmodule
